// File: rtl/trng_word_packer.sv
// Packs the whitened TRNG bit stream into words for the system bus while running a
// continuous repetition-count health test; a health failure latches an alarm and halts packing.
module trng_word_packer #(
    parameter int WORD_W     = 16,
    parameter int RCT_CUTOFF = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              word_ready,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_out,
    output logic              rct_fail,
    output logic [7:0]        drop_count
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int RUN_W = $clog2(RCT_CUTOFF + 1);
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WORD_W - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RCT_CUTOFF);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        FAIL = 2'd2
    } state_t;

    state_t             state;
    logic [WORD_W-1:0]  asm_word;
    logic [CNT_W-1:0]   bitcnt;
    logic [RUN_W-1:0]   run_cnt;
    logic               last_bit;
    logic               seen_bit;

    logic               hold_free;
    logic               rct_active;
    logic               trip;
    logic [RUN_W-1:0]   run_next;
    logic [WORD_W-1:0]  asm_with_bit;

    // The health test sees every valid bit until the alarm latches, even bits that get dropped.
    always_comb begin
        hold_free    = !word_valid || word_ready;
        rct_active   = bit_valid && (state != FAIL);
        run_next     = run_cnt;
        if (!seen_bit || (bit_in != last_bit)) begin
            run_next = RUN_W'(1);
        end else if (run_cnt != RUN_MAX) begin
            run_next = run_cnt + RUN_W'(1);
        end
        trip         = rct_active && (run_next == RUN_MAX);
        asm_with_bit = asm_word | (WORD_W'(bit_in) << bitcnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            asm_word   <= '0;
            bitcnt     <= '0;
            run_cnt    <= '0;
            last_bit   <= 1'b0;
            seen_bit   <= 1'b0;
            word_valid <= 1'b0;
            word_out   <= '0;
            rct_fail   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (rct_active) begin
                run_cnt  <= run_next;
                last_bit <= bit_in;
                seen_bit <= 1'b1;
            end

            // A load below overrides this, giving back-to-back words with no bubble.
            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            case (state)
                FILL: begin
                    if (trip) begin
                        state    <= FAIL;
                        asm_word <= '0;
                        bitcnt   <= '0;
                        rct_fail <= 1'b1;
                    end else if (bit_valid) begin
                        if (bitcnt == LAST_POS) begin
                            if (hold_free) begin
                                word_out   <= asm_with_bit;
                                word_valid <= 1'b1;
                                asm_word   <= '0;
                                bitcnt     <= '0;
                            end else begin
                                asm_word <= asm_with_bit;
                                state    <= FULL;
                            end
                        end else begin
                            asm_word <= asm_with_bit;
                            bitcnt   <= bitcnt + CNT_W'(1);
                        end
                    end
                end

                FULL: begin
                    if (bit_valid && (drop_count != 8'hFF)) begin
                        drop_count <= drop_count + 8'd1;
                    end
                    if (trip) begin
                        state    <= FAIL;
                        asm_word <= '0;
                        bitcnt   <= '0;
                        rct_fail <= 1'b1;
                    end else if (hold_free) begin
                        word_out   <= asm_word;
                        word_valid <= 1'b1;
                        asm_word   <= '0;
                        bitcnt     <= '0;
                        state      <= FILL;
                    end
                end

                FAIL: begin
                    asm_word <= '0;
                    bitcnt   <= '0;
                end

                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trng_word_packer.sv
// Scoreboard bench for trng_word_packer: directed plan cases plus randomized traffic,
// checked against a bit-queue reference model of the packer.
module tb_trng_word_packer;

    localparam int WORD_W     = 16;
    localparam int RCT_CUTOFF = 32;

    logic              clk;
    logic              reset;
    logic              bit_valid;
    logic              bit_in;
    logic              word_ready;
    logic              word_valid;
    logic [WORD_W-1:0] word_out;
    logic              rct_fail;
    logic [7:0]        drop_count;

    int n_compared;
    int n_mismatched;

    trng_word_packer #(
        .WORD_W    (WORD_W),
        .RCT_CUTOFF(RCT_CUTOFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .word_ready(word_ready),
        .word_valid(word_valid),
        .word_out  (word_out),
        .rct_fail  (rct_fail),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic b, input logic r);
        bit_valid  = v;
        bit_in     = b;
        word_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset     = 1'b1;
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_valid", 32'(word_valid), 32'd0);
        checkOutput("reset_word", 32'(word_out), 32'd0);
        checkOutput("reset_rct", 32'(rct_fail), 32'd0);
        checkOutput("reset_drop", 32'(drop_count), 32'd0);
    endtask

    // Reference model: words are built from a queue of accepted bits; storage is
    // tracked as "word held" plus "complete word waiting" flags.
    logic              exp_q[$];
    logic [WORD_W-1:0] word_q[$];
    logic              m_held;
    logic              m_pending;
    logic [WORD_W-1:0] m_pword;
    logic              m_failed;
    int                m_drop;
    int                m_run;
    logic              m_seen;
    logic              m_last;
    logic              m_started;

    initial begin
        m_held = 0; m_pending = 0; m_pword = '0; m_failed = 0;
        m_drop = 0; m_run = 0; m_seen = 0; m_last = 0; m_started = 0;
    end

    always @(posedge clk) begin
        logic              free;
        logic              xfer;
        logic              loaded;
        logic              trip;
        logic [WORD_W-1:0] w;
        if (reset) begin
            m_held = 0; m_pending = 0; m_failed = 0; m_drop = 0;
            m_run = 0; m_seen = 0; m_last = 0; m_started = 1;
            exp_q.delete();
            word_q.delete();
        end else begin
            free   = !m_held || word_ready;
            xfer   = m_held && word_ready;
            loaded = 0;
            trip   = 0;
            if (bit_valid && !m_failed) begin
                if (m_seen && bit_in == m_last)
                    m_run = (m_run < RCT_CUTOFF) ? m_run + 1 : RCT_CUTOFF;
                else
                    m_run = 1;
                m_seen = 1;
                m_last = bit_in;
                trip   = (m_run == RCT_CUTOFF);
            end
            if (!m_failed) begin
                if (m_pending) begin
                    if (bit_valid && m_drop < 255) m_drop++;
                    if (trip) begin
                        m_pending = 0;
                    end else if (free) begin
                        word_q.push_back(m_pword);
                        loaded    = 1;
                        m_pending = 0;
                    end
                end else if (bit_valid && !trip) begin
                    exp_q.push_back(bit_in);
                    if (exp_q.size() == WORD_W) begin
                        w = '0;
                        foreach (exp_q[i]) w[i] = exp_q[i];
                        exp_q.delete();
                        if (free) begin
                            word_q.push_back(w);
                            loaded = 1;
                        end else begin
                            m_pending = 1;
                            m_pword   = w;
                        end
                    end
                end
                if (trip) begin
                    m_failed = 1;
                    exp_q.delete();
                end
            end
            if (loaded) m_held = 1;
            else if (xfer) m_held = 0;
        end
    end

    // Monitor: compares DUT state with the model and pops a word on each transfer.
    always @(negedge clk) begin
        if (m_started) begin
            checkOutput("mon_valid", 32'(word_valid), 32'(m_held));
            checkOutput("mon_rct", 32'(rct_fail), 32'(m_failed));
            checkOutput("mon_drop", 32'(drop_count), 32'(m_drop));
            if (word_valid) begin
                if (word_q.size() == 0) begin
                    checkOutput("mon_unexpected_word", 32'(word_out), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("mon_word", 32'(word_out), 32'(word_q[0]));
                    if (word_ready && !reset) void'(word_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic last_b;
        logic sticky;
        int   pv;
        int   pr;
        logic b;
        n_compared   = 0;
        n_mismatched = 0;
        bit_valid    = 0;
        bit_in       = 0;
        word_ready   = 0;
        reset        = 1;
        @(posedge clk);
        #1;
        doReset();

        // 1: single word, 1 clock latency, one-cycle valid
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, (i % 2) == 0, 1'b1);
        checkOutput("t1_valid", 32'(word_valid), 32'd1);
        checkOutput("t1_word", 32'(word_out), 32'h5555);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t1_valid_drop", 32'(word_valid), 32'd0);
        checkOutput("t1_drop", 32'(drop_count), 32'd0);

        // 2: backpressure, held word plus full assembly, 8 drops
        doReset();
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, (i % 2) == 0, 1'b0);
        checkOutput("t2_drop", 32'(drop_count), 32'd8);
        checkOutput("t2_word", 32'(word_out), 32'h5555);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t2_second_valid", 32'(word_valid), 32'd1);
        checkOutput("t2_second_word", 32'(word_out), 32'h5555);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t2_empty", 32'(word_valid), 32'd0);

        // 3: back-to-back words
        doReset();
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, (i % 2) == 0, 1'b1);
        checkOutput("t3_valid", 32'(word_valid), 32'd1);
        checkOutput("t3_drop", 32'(drop_count), 32'd0);

        // 4: repetition-count trip
        doReset();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            if (i == 15) checkOutput("t4_word", 32'(word_out), 32'hFFFF);
            if (i == 30) checkOutput("t4_rct_before", 32'(rct_fail), 32'd0);
        end
        checkOutput("t4_rct_trip", 32'(rct_fail), 32'd1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'(i % 2), 1'b1);
        checkOutput("t4_no_word", 32'(word_valid), 32'd0);
        checkOutput("t4_drop", 32'(drop_count), 32'd0);
        checkOutput("t4_rct_sticky", 32'(rct_fail), 32'd1);

        // 5: reset mid-word
        doReset();
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'(i % 2), 1'b1);
        doReset();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, i == 0, 1'b1);
        checkOutput("t5_valid", 32'(word_valid), 32'd1);
        checkOutput("t5_word", 32'(word_out), 32'h0001);

        // 6: drop counter saturation
        doReset();
        for (int i = 0; i < 332; i++) applyStimulus(1'b1, (i % 2) == 0, 1'b0);
        checkOutput("t6_drop_sat", 32'(drop_count), 32'd255);

        // Randomized traffic, some segments biased toward long runs
        last_b = 0;
        for (int seg = 0; seg < 10; seg++) begin
            if (seg % 3 == 0) doReset();
            sticky = (seg % 4 == 3);
            pv     = $urandom_range(30, 100);
            pr     = $urandom_range(10, 100);
            for (int c = 0; c < 400; c++) begin
                if (sticky) b = ($urandom_range(0, 99) < 97) ? last_b : ~last_b;
                else        b = 1'($urandom);
                last_b = b;
                applyStimulus($urandom_range(0, 99) < pv, b, $urandom_range(0, 99) < pr);
            end
        end

        for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/trng_word_packer.md
Name: trng_word_packer

Overview:
Downstream consumer of the TRNG output bit FIFO. Takes the serial whitened bit stream (out_valid/out from the trng top level) and runs a continuous repetition-count health test on it. Packs accepted bits into WORD_W-bit words and presents them to the system bus through a valid/ready handshake. Bits that arrive while no word storage is free are dropped and counted. A health failure latches an alarm and stops word production.

Parameters:
WORD_W, 16, output word width in bits; must be at least 2.
RCT_CUTOFF, 32, run length of identical consecutive bits that trips the health alarm; must be at least 2.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
bit_valid  input  1  bit_in is valid this cycle (driven by trng out_valid)
bit_in  input  1  serial random bit (driven by trng out)
word_ready  input  1  consumer accepts word_out this cycle
word_valid  output  1  word_out holds an undelivered word
word_out  output  WORD_W  packed word; first accepted bit in bit 0
rct_fail  output  1  sticky repetition-count alarm
drop_count  output  8  saturating count of dropped bits

Behaviour:
- Reset (sync, active-high): word_valid=0, word_out=0, rct_fail=0, drop_count=0, bit counter=0, run counter=0, last bit=0, FSM=FILL. A reset asserted mid-word discards the partial word and any held word.
- Storage: one assembly register plus one holding register (word_out). A transfer is a beat where word_valid=1 and word_ready=1. Holding is free when word_valid=0 or a transfer occurs in the same cycle.
- Repetition-count test runs on every bit_valid=1 bit, including bits that are dropped:
  - First bit after reset: run=1.
  - Bit equal to the previous bit: run=run+1, saturating at RCT_CUTOFF.
  - Bit different from the previous bit: run=1.
  - When run reaches RCT_CUTOFF, rct_fail goes high on that edge and stays high until reset. The tripping bit is not packed.
- FSM states:
  - FILL:
    - A bit_valid bit is shifted into assembly position bitcnt and bitcnt increments.
    - On the WORD_W-th bit: if holding is free this cycle, the word plus that bit loads holding, word_valid=1 on the next cycle (latency 1 clock from the last bit's edge), bitcnt=0, stay in FILL.
    - Otherwise the word stays complete in assembly and the FSM goes to FULL.
  - FULL:
    - Every bit_valid bit is dropped; drop_count+1, saturating at 255.
    - When holding is free, the assembly word moves to holding, word_valid stays or becomes 1, bitcnt=0, go to FILL. A bit arriving in that same cycle is dropped.
  - FAIL: entered from FILL or FULL on the tripping edge.
    - Assembly is cleared and bitcnt=0.
    - A word already in holding remains deliverable; no new words are loaded.
    - bit_valid bits are ignored; drop_count does not change.
    - Exit only by reset.
- Simultaneous events:
  - Transfer and assembly completion in the same cycle: the new word loads and word_valid stays 1 with no bubble.
  - Health trip and assembly completion in the same cycle: the trip wins and the word is discarded.
- word_out holds stable while word_valid=1 and word_ready=0. word_out is unchanged after a transfer that does not load a new word; only word_valid falls.
- Arithmetic widths:
  - bitcnt: clog2(WORD_W) bits.
  - run counter: clog2(RCT_CUTOFF+1) bits, saturating.
  - drop_count: 8 bits, saturating; never wraps.

Test Plan:
1. word_ready=1, 16 consecutive bits alternating 1,0,1,0,... → word_valid=1 for exactly one cycle, one clock after the 16th bit; word_out=16'h5555; drop_count=0.
2. word_ready=0, 40 alternating bits starting with 1 → first word 16'h5555 held; second word complete in assembly; the last 8 bits dropped, drop_count=8. Raise word_ready → 16'h5555 is delivered, the next cycle delivers 16'h5555, then word_valid=0.
3. word_ready=1, 32 gap-free alternating bits → two words 16'h5555 back-to-back, drop_count=0, no idle cycle needed between them.
4. 32 consecutive 1s (RCT_CUTOFF=32) → word 16'hFFFF delivered after bit 16; rct_fail=1 on the edge of bit 32; bits 17–31 discarded; further bits produce no word_valid and drop_count stays 0.
5. Reset pulse after 7 bits of a word → all outputs 0; the next 16 bits 1,0,0,0,... (1 then fifteen 0s) yield word_out=16'h0001.
6. word_ready=0, two words filled, then 300 further bits alternating → drop_count saturates at 255 and does not wrap.
